// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package mips_fetch_pkg;

   localparam int          FETCH_ADDR_W = 32;
   localparam int          FETCH_DATA_W = 32;
   localparam logic [31:0] FETCH_NOP    = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;

   // Buffer entry layout at the default widths; the top packs the same order.
   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_DATA_W-1:0] data;
      logic                    fault;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; when empty the head output holds the last
// presented entry instead of exposing stale storage.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        head,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int             PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [WIDTH-1:0] hold_q;
   logic             full;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_C);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = empty ? hold_q : mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         hold_q <= '0;
      end else begin
         if (!empty) begin
            hold_q <= mem[rd_ptr];
         end
         // Clear wins over any push or pop in the same cycle.
         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_ok) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
               count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
               count <= count - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok && !clear) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding word read per accepted PC, results buffered
// for decode. Optional FETCH_ALIGN_CHECK_EN turns misaligned PCs into fault entries.
module instruction_fetch
   import mips_fetch_pkg::*;
#(
   parameter int ADDR_W     = FETCH_ADDR_W,
   parameter int DATA_W     = FETCH_DATA_W,
   parameter int FIFO_DEPTH = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pc_in,
   input  logic               pc_valid,
   output logic               pc_ready,
   output logic               mem_req_valid,
   output logic [ADDR_W-1:0]  mem_req_addr,
   input  logic               mem_req_ready,
   input  logic               mem_rsp_valid,
   input  logic [DATA_W-1:0]  mem_rsp_data,
   input  logic               flush,
   output logic               inst_valid,
   output logic [DATA_W-1:0]  inst_data,
   output logic [ADDR_W-1:0]  inst_pc,
   input  logic               inst_ready,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic               inst_fault,
`endif
   output fetch_state_t       dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high; the sender holds valid and its payload stable until then.
   // mem_rsp_valid is the exception: a one-cycle pulse with no ready.

`ifdef FETCH_ALIGN_CHECK_EN
   localparam int ENTRY_W = ADDR_W + DATA_W + 1;
`else
   localparam int ENTRY_W = ADDR_W + DATA_W;
`endif
   localparam int                      CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0]        DEPTH_C = CNT_W'(FIFO_DEPTH);

   fetch_state_t       state_q;
   fetch_state_t       state_d;
   logic [ADDR_W-1:0]  addr_q;
   logic               capture;
   logic               push;
   logic               pop;
   logic [ENTRY_W-1:0] push_entry;
   logic [ENTRY_W-1:0] head_entry;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;

   always_comb begin
      state_d       = state_q;
      pc_ready      = 1'b0;
      mem_req_valid = 1'b0;
      capture       = 1'b0;
      push          = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      push_entry    = {addr_q, mem_rsp_data, 1'b0};
`else
      push_entry    = {addr_q, mem_rsp_data};
`endif
      unique case (state_q)
         IDLE: begin
            // The buffer slot is reserved before issue since responses cannot stall.
            pc_ready = reset && !flush && (fifo_count < DEPTH_C);
            if (pc_valid && pc_ready) begin
`ifdef FETCH_ALIGN_CHECK_EN
               if (pc_in[1:0] != 2'b00) begin
                  push       = 1'b1;
                  push_entry = {pc_in, DATA_W'(FETCH_NOP), 1'b1};
               end else begin
                  capture = 1'b1;
                  state_d = REQ;
               end
`else
               capture = 1'b1;
               state_d = REQ;
`endif
            end
         end
         REQ: begin
            mem_req_valid = 1'b1;
            if (flush) begin
               state_d = mem_req_ready ? DRAIN : IDLE;
            end else if (mem_req_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (flush) begin
               state_d = mem_rsp_valid ? IDLE : DRAIN;
            end else if (mem_rsp_valid) begin
               push    = 1'b1;
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (mem_rsp_valid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // addr_q is both the request address and the PC tagged onto the response.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            addr_q <= pc_in;
         end
      end
   end

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .clear     (flush),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head_entry),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign mem_req_addr = addr_q;
   assign inst_valid   = !fifo_empty;
   assign pop          = inst_valid && inst_ready;
   assign dbg_state    = state_q;
`ifdef FETCH_ALIGN_CHECK_EN
   assign {inst_pc, inst_data, inst_fault} = head_entry;
`else
   assign {inst_pc, inst_data} = head_entry;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: cycle vector table plus hand sequences.
module tb_instruction_fetch;
   import mips_fetch_pkg::*;

   logic         clock = 1'b0;
   logic         reset;
   logic [31:0]  pc_in;
   logic         pc_valid;
   logic         pc_ready;
   logic         mem_req_valid;
   logic [31:0]  mem_req_addr;
   logic         mem_req_ready;
   logic         mem_rsp_valid;
   logic [31:0]  mem_rsp_data;
   logic         flush;
   logic         inst_valid;
   logic [31:0]  inst_data;
   logic [31:0]  inst_pc;
   logic         inst_ready;
`ifdef FETCH_ALIGN_CHECK_EN
   logic         inst_fault;
`endif
   fetch_state_t dbg_state;

   int passed = 0;
   int total  = 0;
   int hs_count = 0;
   int hs_before;

   always #5 clock = ~clock;

   instruction_fetch dut (
      .clock         (clock),
      .reset         (reset),
      .pc_in         (pc_in),
      .pc_valid      (pc_valid),
      .pc_ready      (pc_ready),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_ready (mem_req_ready),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .flush         (flush),
      .inst_valid    (inst_valid),
      .inst_data     (inst_data),
      .inst_pc       (inst_pc),
      .inst_ready    (inst_ready),
`ifdef FETCH_ALIGN_CHECK_EN
      .inst_fault    (inst_fault),
`endif
      .dbg_state     (dbg_state)
   );

   always @(posedge clock) begin
      if (reset && mem_req_valid && mem_req_ready) hs_count <= hs_count + 1;
   end

   typedef struct {
      logic         pv;
      logic [31:0]  pc;
      logic         mrr;
      logic         mrv;
      logic [31:0]  md;
      logic         fl;
      logic         ir;
      logic         e_pr;
      logic         e_mv;
      logic [31:0]  e_ma;
      logic         e_iv;
      logic [31:0]  e_id;
      logic [31:0]  e_ip;
      fetch_state_t e_st;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic pv, input logic [31:0] pc,
                               input logic mrr, input logic mrv, input logic [31:0] md,
                               input logic fl, input logic ir,
                               input logic e_pr, input logic e_mv, input logic [31:0] e_ma,
                               input logic e_iv, input logic [31:0] e_id,
                               input logic [31:0] e_ip, input fetch_state_t e_st);
      vec_t v;
      v.pv = pv; v.pc = pc; v.mrr = mrr; v.mrv = mrv; v.md = md; v.fl = fl; v.ir = ir;
      v.e_pr = e_pr; v.e_mv = e_mv; v.e_ma = e_ma; v.e_iv = e_iv;
      v.e_id = e_id; v.e_ip = e_ip; v.e_st = e_st;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         passed++;
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      pc_valid = 1'b0; pc_in = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      mem_rsp_data = '0; flush = 1'b0; inst_ready = 1'b0;
   endtask

   // Zero-wait fetch: accept, request accepted next cycle, response the cycle after.
   task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data);
      pc_valid = 1'b1; pc_in = pc;
      @(negedge clock);
      check("fetch accept", 64'(pc_ready), 64'(1));
      next_cycle();
      pc_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clock);
      check("fetch req addr", 64'(mem_req_addr), 64'(pc));
      next_cycle();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = data;
      next_cycle();
      mem_rsp_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // pv pc mrr mrv md fl ir | pr mv ma iv id ip state
      vecs.push_back(mk(1, 32'h00, 0, 0, 32'h0,        0, 0, 1, 0, 32'h00, 0, 32'h0,        32'h00, IDLE));
      vecs.push_back(mk(0, 32'h00, 1, 0, 32'h0,        0, 0, 0, 1, 32'h00, 0, 32'h0,        32'h00, REQ));
      vecs.push_back(mk(0, 32'h00, 0, 1, 32'h2008000A, 0, 0, 0, 0, 32'h00, 0, 32'h0,        32'h00, WAIT));
      vecs.push_back(mk(0, 32'h00, 0, 0, 32'h0,        0, 1, 1, 0, 32'h00, 1, 32'h2008000A, 32'h00, IDLE));
      vecs.push_back(mk(0, 32'h00, 0, 0, 32'h0,        0, 0, 1, 0, 32'h00, 0, 32'h2008000A, 32'h00, IDLE));
      vecs.push_back(mk(1, 32'h10, 0, 0, 32'h0,        0, 0, 1, 0, 32'h00, 0, 32'h2008000A, 32'h00, IDLE));
      vecs.push_back(mk(0, 32'h00, 1, 0, 32'h0,        0, 0, 0, 1, 32'h10, 0, 32'h2008000A, 32'h00, REQ));
      vecs.push_back(mk(0, 32'h00, 0, 0, 32'h0,        1, 0, 0, 0, 32'h10, 0, 32'h2008000A, 32'h00, WAIT));
      vecs.push_back(mk(0, 32'h00, 0, 0, 32'h0,        0, 0, 0, 0, 32'h10, 0, 32'h2008000A, 32'h00, DRAIN));
      vecs.push_back(mk(0, 32'h00, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 32'h10, 0, 32'h2008000A, 32'h00, DRAIN));
      vecs.push_back(mk(1, 32'h40, 0, 0, 32'h0,        0, 0, 1, 0, 32'h10, 0, 32'h2008000A, 32'h00, IDLE));
      vecs.push_back(mk(0, 32'h00, 1, 0, 32'h0,        0, 0, 0, 1, 32'h40, 0, 32'h2008000A, 32'h00, REQ));
      vecs.push_back(mk(0, 32'h00, 0, 1, 32'h8C220004, 0, 0, 0, 0, 32'h40, 0, 32'h2008000A, 32'h00, WAIT));
      vecs.push_back(mk(1, 32'h44, 0, 0, 32'h0,        0, 0, 1, 0, 32'h40, 1, 32'h8C220004, 32'h40, IDLE));
      vecs.push_back(mk(0, 32'h00, 1, 0, 32'h0,        0, 0, 0, 1, 32'h44, 1, 32'h8C220004, 32'h40, REQ));
      vecs.push_back(mk(0, 32'h00, 0, 1, 32'h11111111, 1, 0, 0, 0, 32'h44, 1, 32'h8C220004, 32'h40, WAIT));
      vecs.push_back(mk(0, 32'h00, 0, 0, 32'h0,        0, 0, 1, 0, 32'h44, 0, 32'h8C220004, 32'h40, IDLE));
      vecs.push_back(mk(0, 32'h00, 0, 1, 32'h22222222, 0, 0, 1, 0, 32'h44, 0, 32'h8C220004, 32'h40, IDLE));
      vecs.push_back(mk(0, 32'h00, 0, 0, 32'h0,        0, 0, 1, 0, 32'h44, 0, 32'h8C220004, 32'h40, IDLE));
      vecs.push_back(mk(1, 32'h50, 0, 0, 32'h0,        0, 0, 1, 0, 32'h44, 0, 32'h8C220004, 32'h40, IDLE));
      vecs.push_back(mk(0, 32'h00, 0, 0, 32'h0,        1, 0, 0, 1, 32'h50, 0, 32'h8C220004, 32'h40, REQ));
      vecs.push_back(mk(1, 32'h54, 0, 0, 32'h0,        0, 0, 1, 0, 32'h50, 0, 32'h8C220004, 32'h40, IDLE));
      vecs.push_back(mk(0, 32'h00, 1, 0, 32'h0,        1, 0, 0, 1, 32'h54, 0, 32'h8C220004, 32'h40, REQ));
      vecs.push_back(mk(0, 32'h00, 0, 1, 32'h33333333, 0, 0, 0, 0, 32'h54, 0, 32'h8C220004, 32'h40, DRAIN));
      vecs.push_back(mk(1, 32'h60, 0, 0, 32'h0,        1, 0, 0, 0, 32'h54, 0, 32'h8C220004, 32'h40, IDLE));
      vecs.push_back(mk(0, 32'h00, 0, 0, 32'h0,        0, 0, 1, 0, 32'h54, 0, 32'h8C220004, 32'h40, IDLE));

      // clock/reset
      reset = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset pc_ready", 64'(pc_ready), 64'(0));
      check("reset mem_req_valid", 64'(mem_req_valid), 64'(0));
      check("reset mem_req_addr", 64'(mem_req_addr), 64'(0));
      check("reset inst_valid", 64'(inst_valid), 64'(0));
      check("reset inst_data", 64'(inst_data), 64'(0));
      check("reset inst_pc", 64'(inst_pc), 64'(0));
      check("reset state", 64'(dbg_state), 64'(IDLE));
      next_cycle();
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         v = vecs[i];
         pc_valid = v.pv; pc_in = v.pc; mem_req_ready = v.mrr; mem_rsp_valid = v.mrv;
         mem_rsp_data = v.md; flush = v.fl; inst_ready = v.ir;
         @(negedge clock);
         check($sformatf("v%0d pc_ready", i), 64'(pc_ready), 64'(v.e_pr));
         check($sformatf("v%0d mem_req_valid", i), 64'(mem_req_valid), 64'(v.e_mv));
         check($sformatf("v%0d mem_req_addr", i), 64'(mem_req_addr), 64'(v.e_ma));
         check($sformatf("v%0d inst_valid", i), 64'(inst_valid), 64'(v.e_iv));
         check($sformatf("v%0d inst_data", i), 64'(inst_data), 64'(v.e_id));
         check($sformatf("v%0d inst_pc", i), 64'(inst_pc), 64'(v.e_ip));
         check($sformatf("v%0d state", i), 64'(dbg_state), 64'(v.e_st));
         next_cycle();
      end
      idle_inputs();

      // Reset while waiting for a response; the late response must be ignored.
      pc_valid = 1'b1; pc_in = 32'h70;
      next_cycle();
      pc_valid = 1'b0; mem_req_ready = 1'b1;
      next_cycle();
      mem_req_ready = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("midreset state", 64'(dbg_state), 64'(IDLE));
      check("midreset mem_req_addr", 64'(mem_req_addr), 64'(0));
      check("midreset inst_data", 64'(inst_data), 64'(0));
      check("midreset inst_pc", 64'(inst_pc), 64'(0));
      next_cycle();
      reset = 1'b1;
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h44444444;
      @(negedge clock);
      check("late rsp state", 64'(dbg_state), 64'(IDLE));
      next_cycle();
      mem_rsp_valid = 1'b0;
      @(negedge clock);
      check("late rsp not pushed", 64'(inst_valid), 64'(0));
      next_cycle();

      // Fill the buffer with decode stalled; PC 0x8 waits for a pop.
      do_fetch(32'h0, 32'hA1A1A1A1);
      do_fetch(32'h4, 32'hB2B2B2B2);
      pc_valid = 1'b1; pc_in = 32'h8;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check("full pc_ready", 64'(pc_ready), 64'(0));
         check("full head pc", 64'(inst_pc), 64'(32'h0));
         check("full mem_req_valid", 64'(mem_req_valid), 64'(0));
         next_cycle();
      end
      inst_ready = 1'b1;
      @(negedge clock);
      check("pop cycle pc_ready", 64'(pc_ready), 64'(0));
      check("pop cycle head data", 64'(inst_data), 64'(32'hA1A1A1A1));
      next_cycle();
      inst_ready = 1'b0;
      @(negedge clock);
      check("after pop pc_ready", 64'(pc_ready), 64'(1));
      check("after pop head pc", 64'(inst_pc), 64'(32'h4));
      check("after pop head data", 64'(inst_data), 64'(32'hB2B2B2B2));
      next_cycle();
      pc_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clock);
      check("pc8 req valid", 64'(mem_req_valid), 64'(1));
      check("pc8 req addr", 64'(mem_req_addr), 64'(32'h8));
      next_cycle();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hC3C3C3C3;
      next_cycle();
      mem_rsp_valid = 1'b0; inst_ready = 1'b1;
      @(negedge clock);
      check("drain head pc 4", 64'(inst_pc), 64'(32'h4));
      next_cycle();
      @(negedge clock);
      check("drain head pc 8", 64'(inst_pc), 64'(32'h8));
      check("drain head data 8", 64'(inst_data), 64'(32'hC3C3C3C3));
      next_cycle();
      @(negedge clock);
      check("drained empty", 64'(inst_valid), 64'(0));
      next_cycle();
      inst_ready = 1'b0;

      // Memory stalls the request for 4 cycles.
      hs_before = hs_count;
      pc_valid = 1'b1; pc_in = 32'h20;
      @(negedge clock);
      check("stall accept", 64'(pc_ready), 64'(1));
      next_cycle();
      pc_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         check($sformatf("stall%0d req valid", k), 64'(mem_req_valid), 64'(1));
         check($sformatf("stall%0d req addr", k), 64'(mem_req_addr), 64'(32'h20));
         next_cycle();
      end
      mem_req_ready = 1'b1;
      @(negedge clock);
      check("stall release addr", 64'(mem_req_addr), 64'(32'h20));
      next_cycle();
      mem_req_ready = 1'b0;
      @(negedge clock);
      check("stall wait state", 64'(dbg_state), 64'(WAIT));
      check("stall req dropped", 64'(mem_req_valid), 64'(0));
      check("stall one handshake", 64'(hs_count - hs_before), 64'(1));
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55555555;
      next_cycle();
      mem_rsp_valid = 1'b0;
      @(negedge clock);
      check("stall inst_valid", 64'(inst_valid), 64'(1));
      check("stall inst_pc", 64'(inst_pc), 64'(32'h20));
      check("stall inst_data", 64'(inst_data), 64'(32'h55555555));
      inst_ready = 1'b1;
      next_cycle();
      inst_ready = 1'b0;

`ifdef FETCH_ALIGN_CHECK_EN
      // Misaligned PC becomes a fault entry without a memory request.
      hs_before = hs_count;
      pc_valid = 1'b1; pc_in = 32'h6;
      @(negedge clock);
      check("align accept", 64'(pc_ready), 64'(1));
      next_cycle();
      pc_valid = 1'b0;
      @(negedge clock);
      check("align no req", 64'(mem_req_valid), 64'(0));
      check("align state", 64'(dbg_state), 64'(IDLE));
      check("align inst_valid", 64'(inst_valid), 64'(1));
      check("align inst_fault", 64'(inst_fault), 64'(1));
      check("align inst_data", 64'(inst_data), 64'(0));
      check("align inst_pc", 64'(inst_pc), 64'(32'h6));
      check("align no handshake", 64'(hs_count - hs_before), 64'(0));
      next_cycle();
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
